// File: rtl/obi_hci_rsp_buffer.sv
`default_nettype none
// ============================================================================
// Module      : obi_hci_rsp_buffer
// Description : Tracks outstanding OBI transactions and returns HCI response
//               beats in order, with the request ID restored.
// Revision    : 1.0 - initial release
// ============================================================================
module obi_hci_rsp_buffer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      obi_req_i,
  output logic                      obi_gnt_o,
  input  logic [ADDR_W-1:0]         obi_addr_i,
  input  logic                      obi_we_i,
  input  logic [DATA_W/8-1:0]       obi_be_i,
  input  logic [DATA_W-1:0]         obi_wdata_i,
  input  logic [ID_W-1:0]           obi_aid_i,
  output logic                      obi_rvalid_o,
  input  logic                      obi_rready_i,
  output logic [DATA_W-1:0]         obi_rdata_o,
  output logic [ID_W-1:0]           obi_rid_o,
  output logic                      hci_req_o,
  output logic [ADDR_W-1:0]         hci_add_o,
  output logic                      hci_wen_o,
  output logic [DATA_W/8-1:0]       hci_be_o,
  output logic [DATA_W-1:0]         hci_data_o,
  input  logic                      hci_gnt_i,
  input  logic                      hci_r_valid_i,
  input  logic [DATA_W-1:0]         hci_r_data_i,
  output logic [$clog2(MAX_OUTST):0] outst_cnt_o,
  output logic                      spurious_o
);

  localparam int              c_PW  = $clog2(MAX_OUTST);
  localparam logic [c_PW:0]   c_MAX = MAX_OUTST[c_PW:0];
  localparam logic [c_PW:0]   c_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [c_PW:0]        r_alloc_ptr;
  logic [c_PW:0]        r_fill_ptr;
  logic [c_PW:0]        r_head_ptr;
  logic [MAX_OUTST-1:0] r_filled;
  logic                 r_spurious;
  logic [ID_W-1:0]      r_id   [MAX_OUTST];
  logic [DATA_W-1:0]    r_data [MAX_OUTST];

  logic [c_PW:0]        w_cnt;
  logic [c_PW:0]        w_pend_cnt;
  logic                 w_credit;
  logic                 w_pending;
  logic                 w_alloc;
  logic                 w_fill;
  logic                 w_pop;
  logic [c_PW-1:0]      w_alloc_idx;
  logic [c_PW-1:0]      w_fill_idx;
  logic [c_PW-1:0]      w_head_idx;

  assign w_cnt       = r_alloc_ptr - r_head_ptr;
  assign w_pend_cnt  = r_alloc_ptr - r_fill_ptr;
  assign w_credit    = (w_cnt < c_MAX);
  assign w_pending   = (w_pend_cnt != '0);
  assign w_alloc_idx = r_alloc_ptr[c_PW-1:0];
  assign w_fill_idx  = r_fill_ptr[c_PW-1:0];
  assign w_head_idx  = r_head_ptr[c_PW-1:0];

  // Full ring blocks the grant even when a pop happens in the same cycle
  assign hci_req_o   = obi_req_i & w_credit;
  assign obi_gnt_o   = hci_gnt_i & w_credit;
  assign hci_add_o   = obi_addr_i;
  assign hci_wen_o   = ~obi_we_i;
  assign hci_be_o    = obi_be_i;
  assign hci_data_o  = obi_wdata_i;

  assign w_alloc     = obi_req_i & obi_gnt_o;
  assign w_fill      = hci_r_valid_i & w_pending;
  assign w_pop       = obi_rvalid_o & obi_rready_i;

  assign obi_rvalid_o = r_filled[w_head_idx];
  assign obi_rdata_o  = r_data[w_head_idx];
  assign obi_rid_o    = r_id[w_head_idx];
  assign outst_cnt_o  = w_cnt;
  assign spurious_o   = r_spurious;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_filled    <= '0;
      r_spurious  <= 1'b0;
    end else begin
      if (w_alloc) begin
        r_alloc_ptr           <= r_alloc_ptr + c_ONE;
        r_filled[w_alloc_idx] <= 1'b0;
      end
      if (w_fill) begin
        r_fill_ptr           <= r_fill_ptr + c_ONE;
        r_filled[w_fill_idx] <= 1'b1;
      end
      if (w_pop) begin
        r_head_ptr           <= r_head_ptr + c_ONE;
        r_filled[w_head_idx] <= 1'b0;
      end
      if (hci_r_valid_i && !w_pending) begin
        r_spurious <= 1'b1;
      end
    end
  end

  // Payload storage is deliberately left out of reset
  always_ff @(posedge clk_i) begin
    if (w_alloc) begin
      r_id[w_alloc_idx] <= obi_aid_i;
    end
    if (w_fill) begin
      r_data[w_fill_idx] <= hci_r_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_hci_rsp_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_hci_rsp_buffer
// Description : Scoreboard bench for obi_hci_rsp_buffer (MAX_OUTST = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_hci_rsp_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        obi_req = 1'b0;
  logic        obi_gnt;
  logic [31:0] obi_addr = '0;
  logic        obi_we = 1'b0;
  logic [3:0]  obi_be = '0;
  logic [31:0] obi_wdata = '0;
  logic [1:0]  obi_aid = '0;
  logic        obi_rvalid;
  logic        obi_rready = 1'b0;
  logic [31:0] obi_rdata;
  logic [1:0]  obi_rid;
  logic        hci_req;
  logic [31:0] hci_add;
  logic        hci_wen;
  logic [3:0]  hci_be;
  logic [31:0] hci_data;
  logic        hci_gnt = 1'b0;
  logic        hci_r_valid = 1'b0;
  logic [31:0] hci_r_data = '0;
  logic [2:0]  outst_cnt;
  logic        spurious;

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;

  // Scoreboard: ids pushed on grant, data pushed on beat, popped on handshake
  logic [1:0]  q_id[$];
  logic [31:0] q_dat[$];
  logic        m_spur = 1'b0;

  obi_hci_rsp_buffer #(
    .ADDR_W(32), .DATA_W(32), .ID_W(2), .MAX_OUTST(4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .obi_req_i    (obi_req),
    .obi_gnt_o    (obi_gnt),
    .obi_addr_i   (obi_addr),
    .obi_we_i     (obi_we),
    .obi_be_i     (obi_be),
    .obi_wdata_i  (obi_wdata),
    .obi_aid_i    (obi_aid),
    .obi_rvalid_o (obi_rvalid),
    .obi_rready_i (obi_rready),
    .obi_rdata_o  (obi_rdata),
    .obi_rid_o    (obi_rid),
    .hci_req_o    (hci_req),
    .hci_add_o    (hci_add),
    .hci_wen_o    (hci_wen),
    .hci_be_o     (hci_be),
    .hci_data_o   (hci_data),
    .hci_gnt_i    (hci_gnt),
    .hci_r_valid_i(hci_r_valid),
    .hci_r_data_i (hci_r_data),
    .outst_cnt_o  (outst_cnt),
    .spurious_o   (spurious)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so at negedge they equal what
  // the next posedge will sample: compare now, then predict the next state.
  always @(negedge clk) begin
    if (mon_en) begin
      logic e_credit, e_rvalid, e_pending;
      e_credit = (q_id.size() < 4);
      e_rvalid = (q_dat.size() > 0);
      n_checks++;
      if (obi_gnt !== (hci_gnt & e_credit)) begin
        n_fail++; $display("FAIL sb_gnt: got %b want %b", obi_gnt, hci_gnt & e_credit);
      end
      n_checks++;
      if (hci_req !== (obi_req & e_credit)) begin
        n_fail++; $display("FAIL sb_hci_req: got %b want %b", hci_req, obi_req & e_credit);
      end
      n_checks++;
      if (obi_rvalid !== e_rvalid) begin
        n_fail++; $display("FAIL sb_rvalid: got %b want %b", obi_rvalid, e_rvalid);
      end
      if (e_rvalid) begin
        n_checks++;
        if (obi_rid !== q_id[0]) begin
          n_fail++; $display("FAIL sb_rid: got %0d want %0d", obi_rid, q_id[0]);
        end
        n_checks++;
        if (obi_rdata !== q_dat[0]) begin
          n_fail++; $display("FAIL sb_rdata: got %h want %h", obi_rdata, q_dat[0]);
        end
      end
      n_checks++;
      if (outst_cnt !== 3'(q_id.size())) begin
        n_fail++; $display("FAIL sb_cnt: got %0d want %0d", outst_cnt, q_id.size());
      end
      n_checks++;
      if (spurious !== m_spur) begin
        n_fail++; $display("FAIL sb_spurious: got %b want %b", spurious, m_spur);
      end
      if (rst) begin
        q_id.delete();
        q_dat.delete();
        m_spur = 1'b0;
      end else begin
        e_pending = (q_id.size() > q_dat.size());
        if (e_rvalid && obi_rready) begin
          void'(q_id.pop_front());
          void'(q_dat.pop_front());
        end
        if (hci_r_valid) begin
          if (e_pending) q_dat.push_back(hci_r_data);
          else           m_spur = 1'b1;
        end
        if (obi_req && hci_gnt && e_credit) q_id.push_back(obi_aid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at a negedge once the ring is empty or the bound expires
  task automatic drain();
    obi_rready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (outst_cnt == 3'd0 && !obi_rvalid) break;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hci_gnt = 1'b1;
    tick();
    tick();
    mon_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obi_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", obi_rvalid); end
    n_checks++;
    if (outst_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", outst_cnt); end
    n_checks++;
    if (obi_gnt !== 1'b1) begin n_fail++; $display("FAIL reset_gnt: got %b want 1", obi_gnt); end
    tick();
    rst = 1'b0;
    hci_gnt = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    obi_rready = 1'b1;
    obi_req = 1'b1; obi_addr = 32'h100; obi_we = 1'b0; obi_aid = 2'd2; hci_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (hci_add !== 32'h100 || hci_wen !== 1'b1 || hci_req !== 1'b1) begin
      n_fail++; $display("FAIL rd_req_path: got add=%h wen=%b req=%b want 100/1/1", hci_add, hci_wen, hci_req);
    end
    tick();
    obi_req = 1'b0; hci_gnt = 1'b0;
    hci_r_valid = 1'b1; hci_r_data = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if (outst_cnt !== 3'd1 || obi_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rd_pending: got cnt=%0d rvalid=%b want 1/0", outst_cnt, obi_rvalid);
    end
    tick();
    hci_r_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obi_rvalid !== 1'b1 || obi_rdata !== 32'hDEADBEEF || obi_rid !== 2'd2) begin
      n_fail++; $display("FAIL rd_resp: got v=%b d=%h id=%0d want 1/deadbeef/2", obi_rvalid, obi_rdata, obi_rid);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (outst_cnt !== 3'd0) begin n_fail++; $display("FAIL rd_cnt_end: got %0d want 0", outst_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic       got_gnt;
    logic [1:0] exp_rid;
    obi_rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      obi_req = 1'b1; hci_gnt = 1'b1; obi_aid = 2'(i); obi_addr = 32'h200 + 32'(4 * i);
      tick();
    end
    obi_aid = 2'd0;
    @(negedge clk);
    n_checks++;
    if (obi_gnt !== 1'b0 || hci_req !== 1'b0 || outst_cnt !== 3'd4) begin
      n_fail++; $display("FAIL b2b_full: got gnt=%b req=%b cnt=%0d want 0/0/4", obi_gnt, hci_req, outst_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      hci_r_valid = 1'b1; hci_r_data = 32'hA000_0000 + 32'(i);
      tick();
    end
    hci_r_valid = 1'b0;
    obi_rready = 1'b1;
    got_gnt = 1'b0;
    exp_rid = 2'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (obi_rvalid) begin
        n_checks++;
        if (obi_rid !== exp_rid) begin n_fail++; $display("FAIL b2b_order: got %0d want %0d", obi_rid, exp_rid); end
        exp_rid = exp_rid + 2'd1;
      end
      if (obi_gnt) begin got_gnt = 1'b1; break; end
      tick();
    end
    n_checks++;
    if (!got_gnt) begin n_fail++; $display("FAIL b2b_fifth_gnt: got 0 want 1"); end
    tick();
    obi_req = 1'b0; hci_gnt = 1'b0;
    hci_r_valid = 1'b1; hci_r_data = 32'h0000_0055;
    tick();
    hci_r_valid = 1'b0;
    drain();
    n_checks++;
    if (outst_cnt !== 3'd0) begin n_fail++; $display("FAIL b2b_drain: got %0d want 0", outst_cnt); end
    tick();
  endtask

  task automatic test_write();
    obi_rready = 1'b1;
    obi_req = 1'b1; obi_we = 1'b1; obi_be = 4'hF; obi_wdata = 32'h12345678;
    obi_aid = 2'd1; obi_addr = 32'h300; hci_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (hci_wen !== 1'b0 || hci_data !== 32'h12345678 || hci_be !== 4'hF) begin
      n_fail++; $display("FAIL wr_req_path: got wen=%b data=%h be=%h want 0/12345678/f", hci_wen, hci_data, hci_be);
    end
    tick();
    obi_req = 1'b0; obi_we = 1'b0; hci_gnt = 1'b0;
    hci_r_valid = 1'b1; hci_r_data = 32'h0;
    tick();
    hci_r_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obi_rvalid !== 1'b1 || obi_rid !== 2'd1) begin
      n_fail++; $display("FAIL wr_resp: got v=%b id=%0d want 1/1", obi_rvalid, obi_rid);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (outst_cnt !== 3'd0) begin n_fail++; $display("FAIL wr_cnt_end: got %0d want 0", outst_cnt); end
    tick();
  endtask

  task automatic test_full_pop_same_cycle();
    obi_rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      obi_req = 1'b1; hci_gnt = 1'b1; obi_aid = 2'(3 - i);
      tick();
    end
    obi_req = 1'b0;
    hci_r_valid = 1'b1; hci_r_data = 32'hF00D_0000;
    tick();
    hci_r_valid = 1'b0;
    obi_rready = 1'b1; obi_req = 1'b1; obi_aid = 2'd2;
    @(negedge clk);
    n_checks++;
    if (obi_rvalid !== 1'b1 || obi_gnt !== 1'b0 || outst_cnt !== 3'd4) begin
      n_fail++; $display("FAIL full_pop_cycle: got v=%b gnt=%b cnt=%0d want 1/0/4", obi_rvalid, obi_gnt, outst_cnt);
    end
    tick();
    obi_rready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outst_cnt !== 3'd3 || obi_gnt !== 1'b1) begin
      n_fail++; $display("FAIL full_after_pop: got cnt=%0d gnt=%b want 3/1", outst_cnt, obi_gnt);
    end
    tick();
    obi_req = 1'b0; hci_gnt = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outst_cnt !== 3'd4) begin n_fail++; $display("FAIL full_refill: got %0d want 4", outst_cnt); end
    tick();
    for (int i = 0; i < 4; i++) begin
      hci_r_valid = 1'b1; hci_r_data = 32'hF00D_0010 + 32'(i);
      tick();
    end
    hci_r_valid = 1'b0;
    drain();
    n_checks++;
    if (outst_cnt !== 3'd0) begin n_fail++; $display("FAIL full_drain: got %0d want 0", outst_cnt); end
    tick();
  endtask

  task automatic test_spurious();
    obi_rready = 1'b1;
    hci_r_valid = 1'b1; hci_r_data = 32'h0000_0BAD;
    tick();
    hci_r_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obi_rvalid !== 1'b0 || spurious !== 1'b1) begin
      n_fail++; $display("FAIL spur_set: got v=%b spur=%b want 0/1", obi_rvalid, spurious);
    end
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if (spurious !== 1'b1) begin n_fail++; $display("FAIL spur_sticky: got %b want 1", spurious); end
    tick();
  endtask

  task automatic test_reset_mid();
    obi_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      obi_req = 1'b1; hci_gnt = 1'b1; obi_aid = 2'(i + 1);
      tick();
    end
    obi_req = 1'b0; hci_gnt = 1'b0;
    hci_r_valid = 1'b1; hci_r_data = 32'hCAFE_0001;
    tick();
    hci_r_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outst_cnt !== 3'd3 || obi_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: got cnt=%0d v=%b want 3/1", outst_cnt, obi_rvalid);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obi_rvalid !== 1'b0 || outst_cnt !== 3'd0 || spurious !== 1'b0 || obi_gnt !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_post: got v=%b cnt=%0d spur=%b gnt=%b want 0/0/0/0",
                         obi_rvalid, outst_cnt, spurious, obi_gnt);
    end
    hci_gnt = 1'b1;
    #1;
    n_checks++;
    if (obi_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt_follow: got %b want 1", obi_gnt); end
    tick();
    hci_gnt = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write();
    test_full_pop_same_cycle();
    test_spurious();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
